sar_search: RTL and testbench

Sequential binary-search engine that drives the operand side of the team's signed 8-bit magnitude comparator and consumes its E/G/L result flags. It finds an unknown signed 8-bit value X held on the comparator's other operand. It issues successive guesses, reads back whether X equals, is greater than, or is less than each guess, and reports the located value, the probe count and error status. It sits in the arithmetic unit beside the comparator as its initiator.

---
 rtl/sar_search_if.sv | 26 ++
 rtl/sar_search.sv | 153 +++++++++++++++
 tb/tb_sar_search.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// Bus between the binary-search engine and the signed magnitude comparator.
// The engine (master) drives the probe operand and reports status; the other
// side supplies the start request and the comparator's E/G/L result flags.
interface sar_search_if;
  logic       start;
  logic       cmp_E;
  logic       cmp_G;
  logic       cmp_L;
  logic [7:0] guess;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       found;
  logic       err;
  logic [3:0] probes;

  modport master (
    input  start, cmp_E, cmp_G, cmp_L,
    output guess, busy, done, result, found, err, probes
  );

  modport slave (
    output start, cmp_E, cmp_G, cmp_L,
    input  guess, busy, done, result, found, err, probes
  );
endinterface

// File: rtl/sar_search.sv
// Sequential binary search over the signed 8-bit range. Each probe places a
// guess on the comparator, optionally holds it for WAIT_CYCLES extra cycles,
// then narrows [lo, hi] from the E/G/L flags until the value is found, the
// bounds cross, or an illegal flag combination is seen.
module sar_search #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic       clk,
  input logic       rst_n,
  sar_search_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t state;
  state_t state_next;

  // Bounds are one bit wider than the data so lo can reach 128 and hi -129.
  logic signed [8:0] lo;
  logic signed [8:0] hi;
  logic signed [9:0] sum;
  logic signed [8:0] mid;
  logic signed [8:0] mid_inc;
  logic signed [8:0] mid_dec;
  logic        [3:0] wait_cnt;

  logic [2:0] flags;
  logic       sample;
  logic       hit_e;
  logic       hit_g;
  logic       hit_l;
  logic       illegal;
  logic       cross_g;
  logic       cross_l;

  // The midpoint is a floor division: dropping the LSB of the signed sum.
  assign sum     = {lo[8], lo} + {hi[8], hi};
  assign mid     = 9'(sum >>> 1);
  assign mid_inc = mid + 9'sd1;
  assign mid_dec = mid - 9'sd1;

  assign flags   = {bus.cmp_E, bus.cmp_G, bus.cmp_L};
  assign sample  = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign hit_e   = (flags == 3'b100);
  assign hit_g   = (flags == 3'b010);
  assign hit_l   = (flags == 3'b001);
  assign illegal = !(hit_e || hit_g || hit_l);
  assign cross_g = (mid_inc > hi);
  assign cross_l = (lo > mid_dec);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision; a probe ends the search on E, on bad flags, or when
  // the narrowed bounds cross.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (sample) begin
          if (illegal || hit_e) begin
            state_next = S_DONE;
          end else if (hit_g) begin
            state_next = cross_g ? S_DONE : S_LOAD;
          end else begin
            state_next = cross_l ? S_DONE : S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: bounds, probe operand, hold counter and the registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo          <= '0;
      hi          <= '0;
      wait_cnt    <= '0;
      bus.guess   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.found   <= 1'b0;
      bus.err     <= 1'b0;
      bus.probes  <= '0;
    end else begin
      bus.busy <= (state_next == S_LOAD) || (state_next == S_WAIT);
      bus.done <= (state == S_WAIT) && (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo         <= -9'sd128;
            hi         <= 9'sd127;
            bus.probes <= '0;
            bus.result <= '0;
            bus.found  <= 1'b0;
            bus.err    <= 1'b0;
          end
        end
        S_LOAD: begin
          bus.guess  <= mid[7:0];
          bus.probes <= bus.probes + 4'd1;
          wait_cnt   <= WAIT_INIT;
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (illegal) begin
            bus.err   <= 1'b1;
            bus.found <= 1'b0;
          end else if (hit_e) begin
            bus.result <= bus.guess;
            bus.found  <= 1'b1;
          end else if (hit_g) begin
            lo <= mid_inc;
          end else begin
            hi <= mid_dec;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Testbench for sar_search: two instances (no hold, and a 3-cycle hold)
// driven by a behavioural comparator; expected guesses and status come from a
// plain-integer binary search computed in the bench.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst_n;

  sar_search_if ifa ();
  sar_search_if ifb ();

  sar_search #(.WAIT_CYCLES(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sar_search #(.WAIT_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;

  int         x_val = 0;
  int         mode = 0;
  logic       glitch = 1'b0;
  logic [2:0] garbage = 3'b000;
  logic       sel = 1'b0;

  int exp_g[$];
  int exp_found;
  int exp_err;
  int exp_result;

  logic [7:0] o_guess;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_found;
  logic       o_err;
  logic [3:0] o_probes;

  // Free-running clock.
  always #5 clk = ~clk;

  // Comparator flags for a given operand under the selected behaviour mode:
  // 0 = honest comparator, 1 = stuck G, 2 = E and G both high.
  function automatic logic [2:0] ref_flags(input logic [7:0] g, input int x, input int md);
    int gs;
    gs = $signed(g);
    case (md)
      1:       ref_flags = 3'b010;
      2:       ref_flags = 3'b110;
      default: ref_flags = {x == gs, x > gs, x < gs};
    endcase
  endfunction

  // Comparator model for each instance; noise replaces the flags whenever
  // the next edge is not a sampling edge.
  always_comb begin
    {ifa.cmp_E, ifa.cmp_G, ifa.cmp_L} = glitch ? garbage : ref_flags(ifa.guess, x_val, mode);
    {ifb.cmp_E, ifb.cmp_G, ifb.cmp_L} = glitch ? garbage : ref_flags(ifb.guess, x_val, mode);
  end

  // Outputs of whichever instance the current step exercises.
  always_comb begin
    o_guess  = sel ? ifb.guess  : ifa.guess;
    o_busy   = sel ? ifb.busy   : ifa.busy;
    o_done   = sel ? ifb.done   : ifa.done;
    o_result = sel ? ifb.result : ifa.result;
    o_found  = sel ? ifb.found  : ifa.found;
    o_err    = sel ? ifb.err    : ifa.err;
    o_probes = sel ? ifb.probes : ifa.probes;
  end

  function automatic logic [7:0] b8(input int v);
    b8 = v[7:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference binary search on plain integers.
  task automatic build_model(input int x, input int md);
    int lo, hi, s, m;
    exp_g.delete();
    exp_found  = 0;
    exp_err    = 0;
    exp_result = 0;
    lo = -128;
    hi = 127;
    for (int n = 0; n < 20; n++) begin
      s = lo + hi;
      m = (s - (((s % 2) + 2) % 2)) / 2;
      exp_g.push_back(m);
      if (md == 2) begin
        exp_err = 1;
        break;
      end
      if (md == 0 && x == m) begin
        exp_found  = 1;
        exp_result = m;
        break;
      end
      if (md == 1 || x > m) lo = m + 1;
      else                  hi = m - 1;
      if (lo > hi) break;
    end
  endtask

  task automatic set_start(input logic which, input logic v);
    if (which) ifb.start = v;
    else       ifa.start = v;
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_a_guess"},  32'(ifa.guess),  0);
    check_output({name, "_a_busy"},   32'(ifa.busy),   0);
    check_output({name, "_a_done"},   32'(ifa.done),   0);
    check_output({name, "_a_result"}, 32'(ifa.result), 0);
    check_output({name, "_a_found"},  32'(ifa.found),  0);
    check_output({name, "_a_err"},    32'(ifa.err),    0);
    check_output({name, "_a_probes"}, 32'(ifa.probes), 0);
    check_output({name, "_b_guess"},  32'(ifb.guess),  0);
    check_output({name, "_b_result"}, 32'(ifb.result), 0);
    check_output({name, "_b_found"},  32'(ifb.found),  0);
    check_output({name, "_b_probes"}, 32'(ifb.probes), 0);
  endtask

  // One full search: start, per-cycle guess/probe/busy checks, final status.
  task automatic apply_stimulus(input logic which, input int x, input int md,
                                input int w, input int extra_at, input string name);
    int p, per, total, j;
    build_model(x, md);
    p     = exp_g.size();
    per   = 2 + w;
    total = p * per;
    sel   = which;
    x_val = x;
    mode  = md;
    $display("[TB] %s: x=%0d mode=%0d probes=%0d", name, x, md, p);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    check_output({name, "_busy0"}, 32'(o_busy), 1);
    check_output({name, "_done0"}, 32'(o_done), 0);
    glitch  = 1'b1;
    garbage = 3'($urandom);
    for (int c = 1; c <= total + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      set_start(which, (c == extra_at) && (extra_at <= total));
      if (c <= total) begin
        j = (c - 1) / per;
        check_output({name, "_guess"},  32'(o_guess),  32'(b8(exp_g[j])));
        check_output({name, "_probes"}, 32'(o_probes), j + 1);
      end
      if (c < total) begin
        check_output({name, "_busy"}, 32'(o_busy), 1);
        check_output({name, "_done"}, 32'(o_done), 0);
      end else if (c == total) begin
        check_output({name, "_done_end"},  32'(o_done),   1);
        check_output({name, "_busy_end"},  32'(o_busy),   0);
        check_output({name, "_found"},     32'(o_found),  exp_found);
        check_output({name, "_err"},       32'(o_err),    exp_err);
        check_output({name, "_result"},    32'(o_result), 32'(b8(exp_result)));
      end else begin
        check_output({name, "_done_pulse"}, 32'(o_done),   0);
        check_output({name, "_busy_idle"},  32'(o_busy),   0);
        check_output({name, "_found_held"}, 32'(o_found),  exp_found);
        check_output({name, "_probes_held"},32'(o_probes), p);
      end
      glitch  = ((c + 1) % per) != 0;
      garbage = 3'($urandom);
    end
    glitch = 1'b0;
    set_start(which, 1'b0);
  endtask

  // Starts a long search on the no-hold instance and resets it mid-flight.
  task automatic reset_mid_search(input int x);
    sel   = 1'b0;
    x_val = x;
    mode  = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check_output("mid_probes_before_reset", 32'(ifa.probes), 4);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rx;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    apply_stimulus(1'b0, 37, 0, 0, -1, "x37");
    apply_stimulus(1'b0, -128, 0, 0, -1, "xmin");
    apply_stimulus(1'b0, 127, 0, 0, -1, "xmax");
    apply_stimulus(1'b1, 0, 0, 3, -1, "w3_x0");
    apply_stimulus(1'b0, 0, 1, 0, -1, "stuck_g");
    apply_stimulus(1'b0, 5, 2, 0, -1, "e_and_g");
    apply_stimulus(1'b0, 37, 0, 0, 5, "start_while_busy");
    apply_stimulus(1'b1, -77, 0, 3, 9, "w3_start_while_busy");

    for (int i = 0; i < 10; i++) begin
      rx = int'($urandom_range(255, 0)) - 128;
      apply_stimulus(1'(i % 2), rx, 0, (i % 2) * 3, (i % 3 == 0) ? 3 : -1, "random");
    end

    reset_mid_search(37);
    apply_stimulus(1'b0, 37, 0, 0, -1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
